// File: rtl/imm_pkg.sv
// Immediate-generation package.
// Holds the format-select encoding and the shared decode function that turns a
// 32-bit RISC-V instruction word into a 64-bit extended immediate. Callers keep
// the low XLEN bits. The compressed-instruction expander is also expected to
// reuse this function.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_fmt_e;

  // Always builds the full 64-bit value. The signed formats replicate instr[31]
  // all the way up, so truncating to 32 bits gives the XLEN=32 result directly.
  function automatic logic [63:0] imm_decode(input logic [31:0]  instr,
                                             input imm_fmt_e     fmt,
                                             input int unsigned  xlen);
    logic s;
    s = instr[31];
    imm_decode = '0;
    case (fmt)
      IMM_I:     imm_decode = {{52{s}}, instr[31:20]};
      IMM_S:     imm_decode = {{52{s}}, instr[31:25], instr[11:7]};
      IMM_B:     imm_decode = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm_decode = {{32{s}}, instr[31:12], 12'b0};
      IMM_J:     imm_decode = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // RV64 shift amounts use one extra bit.
      IMM_SHAMT: imm_decode = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_ZIMM:  imm_decode = {59'b0, instr[19:15]};
      default:   imm_decode = '0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus for imm_gen_pipe.
// Input side:  in_valid, in_ready, in_instr, in_fmt, in_tag.
// Output side: out_valid, out_ready, out_imm, out_tag, out_illegal.
// master: the producer/consumer around the block. slave: the block itself.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  imm_fmt_e         in_fmt;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_fmt, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_fmt, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_pipe_stage.sv
// One elastic valid/ready register slice.
// Ports: clk, rst_n (async, active-low), flush (sync, clears valid),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream).
// in_ready is combinational from out_ready (no skid buffer), so a chain of
// these forms a combinational ready path back to the head.
module imm_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
    // Data may still load during a flush; only the valid bit matters.
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator.
// Decodes the immediate combinationally from bus.in_instr/in_fmt and carries
// {illegal, tag, imm} through STAGES elastic register slices. Latency equals
// STAGES; full throughput when out_ready is held high.
// Ports: clk, rst_n (async, active-low), flush (sync, drops all in-flight
//        entries and any entry offered in the same cycle), bus (slave side of
//        imm_gen_pipe_if).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  localparam int unsigned PayloadW = XLEN + TAG_W + 1;

  logic [63:0]     imm_full;
  logic [XLEN-1:0] imm;
  logic            illegal;

  always_comb begin
    imm_full = imm_decode(bus.in_instr, bus.in_fmt, XLEN);
    illegal  = (bus.in_fmt == IMM_RSVD);
  end

  assign imm = imm_full[XLEN-1:0];

  if (XLEN < 64) begin : g_trim
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_full[63:XLEN];
  end

  // Element k is the interface between slice k-1 and slice k; element 0 is
  // the block input and element STAGES is the block output.
  logic                valid [STAGES+1];
  logic                ready [STAGES+1];
  logic [PayloadW-1:0] data  [STAGES+1];

  assign valid[0]      = bus.in_valid;
  assign data[0]       = {illegal, bus.in_tag, imm};
  assign bus.in_ready  = ready[0];
  assign ready[STAGES] = bus.out_ready;
  assign bus.out_valid = valid[STAGES];
  assign {bus.out_illegal, bus.out_tag, bus.out_imm} = data[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    imm_pipe_stage #(
      .Width(PayloadW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (valid[k]),
      .in_ready (ready[k]),
      .in_data  (data[k]),
      .out_valid(valid[k+1]),
      .out_ready(ready[k+1]),
      .out_data (data[k+1])
    );
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Three instances:
//   a: XLEN=32 STAGES=1, b: XLEN=64 STAGES=3, c: XLEN=32 STAGES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_a, flush_b, flush_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus_a ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus_b ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus_c ();

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a)
  );
  imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b)
  );
  imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .bus(bus_c)
  );

  task automatic test_reset();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_imm !== 32'h0 || bus_a.out_tag !== 8'h0 ||
        bus_a.out_illegal !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: v=%b imm=%h tag=%h ill=%b rdy=%b, want v=0 imm=0 tag=0 ill=0 rdy=1",
               bus_a.out_valid, bus_a.out_imm, bus_a.out_tag, bus_a.out_illegal, bus_a.in_ready);
    end
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.out_imm !== 64'h0 || bus_b.out_tag !== 8'h0 ||
        bus_b.out_illegal !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: v=%b imm=%h tag=%h ill=%b rdy=%b, want v=0 imm=0 tag=0 ill=0 rdy=1",
               bus_b.out_valid, bus_b.out_imm, bus_b.out_tag, bus_b.out_illegal, bus_b.in_ready);
    end
    checks++;
    if (bus_c.out_valid !== 1'b0 || bus_c.out_imm !== 32'h0 || bus_c.out_tag !== 8'h0 ||
        bus_c.out_illegal !== 1'b0 || bus_c.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_c: v=%b imm=%h tag=%h ill=%b rdy=%b, want v=0 imm=0 tag=0 ill=0 rdy=1",
               bus_c.out_valid, bus_c.out_imm, bus_c.out_tag, bus_c.out_illegal, bus_c.in_ready);
    end
  endtask

  task automatic test_i_fmt();
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_instr  = 32'hFFF0_0093;
    bus_a.in_fmt    = IMM_I;
    bus_a.in_tag    = 8'h11;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_imm !== 32'hFFFF_FFFF ||
        bus_a.out_illegal !== 1'b0 || bus_a.out_tag !== 8'h11) begin
      errors++;
      $display("FAIL i_fmt: v=%b imm=%h ill=%b tag=%h, want v=1 imm=ffffffff ill=0 tag=11",
               bus_a.out_valid, bus_a.out_imm, bus_a.out_illegal, bus_a.out_tag);
    end
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL i_fmt_drain: out_valid=%b want 0", bus_a.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr [4];
    imm_fmt_e    fmt   [4];
    logic [31:0] exp   [4];
    instr = '{32'h0011_2623, 32'hFE00_0EE3, 32'h1234_50B7, 32'h8000_00EF};
    fmt   = '{IMM_S, IMM_B, IMM_U, IMM_J};
    exp   = '{32'h0000_000C, 32'hFFFF_FFFC, 32'h1234_5000, 32'hFFF0_0000};
    bus_a.out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_imm !== exp[c-1] ||
            bus_a.out_tag !== 8'(c - 1) || bus_a.out_illegal !== 1'b0) begin
          errors++;
          $display("FAIL b2b_%0d: v=%b imm=%h tag=%h ill=%b, want v=1 imm=%h tag=%h ill=0",
                   c - 1, bus_a.out_valid, bus_a.out_imm, bus_a.out_tag, bus_a.out_illegal,
                   exp[c-1], 8'(c - 1));
        end
      end
      if (c < 4) begin
        bus_a.in_valid = 1'b1;
        bus_a.in_instr = instr[c];
        bus_a.in_fmt   = fmt[c];
        bus_a.in_tag   = 8'(c);
      end else begin
        bus_a.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b want 0", bus_a.out_valid);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_instr  = 32'hFFFF_FFFF;
    bus_a.in_fmt    = IMM_RSVD;
    bus_a.in_tag    = 8'h5A;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_imm !== 32'h0 ||
        bus_a.out_illegal !== 1'b1 || bus_a.out_tag !== 8'h5A) begin
      errors++;
      $display("FAIL illegal: v=%b imm=%h ill=%b tag=%h, want v=1 imm=0 ill=1 tag=5a",
               bus_a.out_valid, bus_a.out_imm, bus_a.out_illegal, bus_a.out_tag);
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] instr [4];
    imm_fmt_e    fmt   [4];
    logic [63:0] exp   [4];
    int          idx;
    instr = '{32'hFFF0_0093, 32'h8000_00B7, 32'h03F0_9093, 32'h000F_D073};
    fmt   = '{IMM_I, IMM_U, IMM_SHAMT, IMM_ZIMM};
    exp   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h3F, 64'h1F};
    bus_b.out_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      idx = c - 3;
      checks++;
      if (idx >= 0 && idx < 4) begin
        if (bus_b.out_valid !== 1'b1 || bus_b.out_imm !== exp[idx] ||
            bus_b.out_tag !== 8'(idx + 8'h20)) begin
          errors++;
          $display("FAIL x64_%0d: v=%b imm=%h tag=%h, want v=1 imm=%h tag=%h", idx,
                   bus_b.out_valid, bus_b.out_imm, bus_b.out_tag, exp[idx], 8'(idx + 8'h20));
        end
      end else if (bus_b.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL x64_idle_c%0d: out_valid=%b want 0", c, bus_b.out_valid);
      end
      if (c < 4) begin
        bus_b.in_valid = 1'b1;
        bus_b.in_instr = instr[c];
        bus_b.in_fmt   = fmt[c];
        bus_b.in_tag   = 8'(c + 8'h20);
      end else begin
        bus_b.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    bus_c.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus_c.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_accept_%0d: in_ready=%b want 1", c, bus_c.in_ready);
      end
      bus_c.in_valid = 1'b1;
      bus_c.in_instr = 32'h0010_0093 + (32'(c) << 20);
      bus_c.in_fmt   = IMM_I;
      bus_c.in_tag   = 8'(8'h30 + c);
    end
    // Third entry is offered but must be refused while full and stalled.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_c.in_instr = 32'h0030_0093;
      bus_c.in_tag   = 8'h32;
      checks++;
      if (bus_c.in_ready !== 1'b0 || bus_c.out_valid !== 1'b1 ||
          bus_c.out_imm !== 32'h1 || bus_c.out_tag !== 8'h30) begin
        errors++;
        $display("FAIL stall_hold_%0d: rdy=%b v=%b imm=%h tag=%h, want rdy=0 v=1 imm=1 tag=30",
                 c, bus_c.in_ready, bus_c.out_valid, bus_c.out_imm, bus_c.out_tag);
      end
    end
    bus_c.in_valid  = 1'b0;
    bus_c.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_c.out_valid !== 1'b1 || bus_c.out_imm !== 32'h2 || bus_c.out_tag !== 8'h31) begin
      errors++;
      $display("FAIL stall_release: v=%b imm=%h tag=%h, want v=1 imm=2 tag=31",
               bus_c.out_valid, bus_c.out_imm, bus_c.out_tag);
    end
    @(negedge clk);
    checks++;
    if (bus_c.out_valid !== 1'b0 || bus_c.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain: v=%b rdy=%b, want v=0 rdy=1", bus_c.out_valid, bus_c.in_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    bus_b.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b1;
      bus_b.in_instr = 32'h0010_0093 + (32'(c) << 20);
      bus_b.in_fmt   = IMM_I;
      bus_b.in_tag   = 8'(8'h40 + c);
    end
    @(negedge clk);
    checks++;
    if (bus_b.in_ready !== 1'b0 || bus_b.out_valid !== 1'b1 || bus_b.out_tag !== 8'h40) begin
      errors++;
      $display("FAIL flush_full: rdy=%b v=%b tag=%h, want rdy=0 v=1 tag=40",
               bus_b.in_ready, bus_b.out_valid, bus_b.out_tag);
    end
    flush_b        = 1'b1;
    bus_b.in_valid = 1'b1;
    bus_b.in_instr = 32'h0070_0093;
    bus_b.in_tag   = 8'h4F;
    @(negedge clk);
    flush_b        = 1'b0;
    bus_b.in_valid = 1'b0;
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: v=%b rdy=%b, want v=0 rdy=1", bus_b.out_valid, bus_b.in_ready);
    end
    bus_b.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_b.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_emerge: valid outputs seen=%0d want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b1;
      bus_b.in_instr = 32'hFFF0_0093;
      bus_b.in_fmt   = IMM_I;
      bus_b.in_tag   = 8'(8'h60 + c);
    end
    checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_tag !== 8'h60) begin
      errors++;
      $display("FAIL areset_pre: v=%b tag=%h, want v=1 tag=60", bus_b.out_valid, bus_b.out_tag);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.out_imm !== 64'h0 || bus_b.out_tag !== 8'h0 ||
        bus_b.out_illegal !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: v=%b imm=%h tag=%h ill=%b rdy=%b, want v=0 imm=0 tag=0 ill=0 rdy=1",
               bus_b.out_valid, bus_b.out_imm, bus_b.out_tag, bus_b.out_illegal, bus_b.in_ready);
    end
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    rst_n          = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus_b.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_discard_%0d: out_valid=%b want 0", c, bus_b.out_valid);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    flush_c = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_instr = '0; bus_a.in_fmt = IMM_I; bus_a.in_tag = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_instr = '0; bus_b.in_fmt = IMM_I; bus_b.in_tag = '0;
    bus_b.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_instr = '0; bus_c.in_fmt = IMM_I; bus_c.in_tag = '0;
    bus_c.out_ready = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_i_fmt();
    test_back_to_back();
    test_illegal();
    test_xlen64();
    test_stall();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate extender in the decode path.
- Takes a full 32-bit RISC-V instruction word plus a format select.
- Produces the sign- or zero-extended immediate at XLEN width through 1..3 elastic valid/ready register stages.
- Carries a user tag (PC or ROB index) alongside each result.
- Adds shift-amount and CSR-zimm formats, an illegal-format flag, and a pipeline flush.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
STAGES, 1, number of register stages, 1..3; equals latency in cycles.
TAG_W, 8, width of the sideband tag carried with each instruction.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous flush; drops all in-flight entries.
in_valid  in  1  input entry valid.
in_ready  out  1  block can accept an input this cycle.
in_instr  in  32  instruction word.
in_fmt  in  3  format select (encoding in package).
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts the output.
out_imm  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag of the output entry.
out_illegal  out  1  format select was reserved (7).

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit clears to 0 and data clears to 0. Therefore out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=1. A reset mid-transfer discards all entries.
- Format decode is combinational into stage 0. In every sext below, the sign bit is instr[31], extended to XLEN:
  - 0 I: sext(instr[31:20])
  - 1 S: sext({instr[31:25],instr[11:7]})
  - 2 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 3 U: sext({instr[31:12],12'b0}); for XLEN=64 bits 63:32 copy instr[31].
  - 4 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 5 SHAMT: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 6 ZIMM: zero-extend instr[19:15].
  - 7 reserved: imm=0, illegal=1. For all other formats illegal=0.
- Pipeline:
  - Stage k holds {valid, imm, tag, illegal}.
  - Stage k loads when its ready is high: ready_k = !valid_k || ready_(k+1). For the last stage, ready_(k+1) is out_ready.
  - in_ready = ready_0. This is a combinational ready chain; no skid buffer.
  - A transfer occurs on any edge where valid&&ready are both high on that interface.
  - Latency: an input accepted at edge N appears on out_* after edge N+STAGES-1, i.e. visible in cycle N+STAGES-1 when STAGES=1 counts the registering edge. Precisely: an entry accepted on edge E is presented at the outputs from edge E+(STAGES-1) onward.
  - Full throughput: one entry per cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, out_imm, out_tag and out_illegal stay stable. A full pipe drives in_ready=0. Entries are never dropped or duplicated.
- Flush:
  - On an edge with flush=1, all valid bits clear.
  - An input offered in the same cycle is discarded, even though in_ready may read 1.
  - An output presented with out_ready=1 in the flush cycle counts as consumed.
  - Flush has priority over load.
- Data registers need not clear on flush. Only valid bits matter.
- For XLEN=32, U-format bit 31 is instr[31] with no further extension.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic[2:0] imm_fmt_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSVD}.
  - A function imm_decode(instr, fmt, xlen), shared with the future compressed-instruction expander.
- One sub-module: imm_pipe_stage. It is a single valid/ready register slice parametrised by payload width and is instantiated STAGES times in a generate loop.

Test Plan:
- XLEN=32, STAGES=1, fmt I, instr 0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- Back-to-back, one per cycle: S 0x00112623 -> 0x0000000C; B 0xFE000EE3 -> 0xFFFFFFFC; U 0x123450B7 -> 0x12345000; J 0x800000EF -> 0xFFF00000. All emerge in order with no bubbles.
- XLEN=64, STAGES=3:
  - I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF after 3 edges.
  - U 0x800000B7 -> 0xFFFFFFFF80000000.
  - SHAMT 0x03F09093 -> 0x3F.
  - ZIMM 0x000FD073 -> 0x1F.
- STAGES=2, hold out_ready=0 while pushing 3 entries -> 2 accepted, in_ready=0 on the third, out_* stable. Release out_ready -> entries emerge in order, then in_ready=1.
- STAGES=3 with pipe full, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0 and no entry ever emerges. rst_n pulsed low mid-stream -> outputs 0 immediately, without waiting for a clock edge.
- fmt 7, any instr, tag 0x5A -> out_imm=0, out_illegal=1, out_tag=0x5A.
